// File: rtl/lisa_qspi_engine_if.sv
// Downstream request bus between the LISA QSPI arbiter (master) and the
// QSPI engine (slave): request fields in, per-word ready/rdata and done out.
interface lisa_qspi_engine_if #(
  parameter int CHIP_SELECTS = 2
);
  logic                    valid;
  logic [23:0]             addr;
  logic [15:0]             wdata;
  logic [1:0]              wstrb;
  logic [3:0]              xfer_len;
  logic [CHIP_SELECTS-1:0] ce_ctrl;
  logic                    custom_spi_cmd;
  logic [7:0]              cmd_quad_write;
  logic [15:0]             rdata;
  logic                    ready;
  logic                    xfer_done;

  modport master (
    output valid, addr, wdata, wstrb, xfer_len, ce_ctrl, custom_spi_cmd, cmd_quad_write,
    input  rdata, ready, xfer_done
  );

  modport slave (
    input  valid, addr, wdata, wstrb, xfer_len, ce_ctrl, custom_spi_cmd, cmd_quad_write,
    output rdata, ready, xfer_done
  );
endinterface

// File: rtl/lisa_qspi_engine.sv
// Quad-mode QSPI PSRAM engine: runs one latched request as a
// command/address/dummy/data sequence, two clk per sclk period.
module lisa_qspi_engine #(
  parameter int          CHIP_SELECTS = 2,
  parameter int          DUMMY_CYCLES = 6,
  parameter logic [7:0]  CMD_READ     = 8'hEB,
  parameter logic [7:0]  CMD_WRITE    = 8'h38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lisa_qspi_engine_if.slave       bus,
  output logic                    sclk,
  output logic [CHIP_SELECTS-1:0] ce_n,
  output logic [3:0]              sio_out,
  output logic [3:0]              sio_oe,
  input  logic [3:0]              sio_in
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END} state_t;

  state_t                  state_q, state_d;
  logic                    ph_q, ph_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [4:0]              words_q, words_d;
  logic                    wr_q, wr_d;
  logic                    byte_q, byte_d;
  logic                    swap_q, swap_d;
  logic [CHIP_SELECTS-1:0] ce_q, ce_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    rdy_q, rdy_d;

  logic [23:0]             addr_q, addr_d;
  logic [7:0]              op_q, op_d;
  logic [15:0]             wsh_q, wsh_d;
  logic [11:0]             rsh_q, rsh_d;

  logic [15:0]             wsrc, wcur, rword;
  logic [23:0]             ash;
  logic                    wr_rdy, done;

  // Word byte order on the wire: low byte then high byte, high nibble first.
  function automatic logic [3:0] word_nib(input logic [15:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:4];
      2'd1:    return w[3:0];
      2'd2:    return w[15:12];
      default: return w[11:8];
    endcase
  endfunction

  assign bus.rdata     = rdata_q;
  assign bus.ready     = rdy_q | wr_rdy;
  assign bus.xfer_done = done;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    swap_d   = swap_q;
    ce_d     = ce_q;
    addr_d   = addr_q;
    op_d     = op_q;
    wsh_d    = wsh_q;
    rsh_d    = rsh_q;
    rdata_d  = rdata_q;
    rdy_d    = 1'b0;
    wr_rdy   = 1'b0;
    done     = 1'b0;
    sclk     = 1'b0;
    ce_n     = '1;
    sio_out  = 4'h0;
    sio_oe   = 4'h0;
    // Upper-byte single writes are swapped so both byte cases shift out bits [7:0].
    wsrc     = swap_q ? {bus.wdata[7:0], bus.wdata[15:8]} : bus.wdata;
    wcur     = (cnt_q == 4'd0) ? wsrc : wsh_q;
    rword    = {rsh_q, sio_in};
    ash      = addr_q << {cnt_q[2:0], 2'b00};

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          wr_d    = |bus.wstrb;
          byte_d  = (bus.wstrb == 2'b01) || (bus.wstrb == 2'b10);
          swap_d  = (bus.wstrb == 2'b10);
          ce_d    = bus.ce_ctrl;
          addr_d  = (bus.wstrb == 2'b10) ? bus.addr + 24'd1 : bus.addr;
          op_d    = (bus.wstrb == 2'b00) ? CMD_READ :
                    (bus.custom_spi_cmd ? bus.cmd_quad_write : CMD_WRITE);
          if ((bus.wstrb == 2'b01) || (bus.wstrb == 2'b10)) words_d = 5'd1;
          else if (bus.xfer_len == 4'd0)                    words_d = 5'd16;
          else                                              words_d = {1'b0, bus.xfer_len};
          ph_d    = 1'b0;
          cnt_d   = 4'd0;
          state_d = CMD;
        end
      end
      CMD: begin
        sclk    = ph_q;
        ce_n    = ~ce_q;
        sio_oe  = 4'hF;
        sio_out = cnt_q[0] ? op_q[3:0] : op_q[7:4];
        ph_d    = ~ph_q;
        if (ph_q) begin
          if (cnt_q == 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ADDR;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ADDR: begin
        sclk    = ph_q;
        ce_n    = ~ce_q;
        sio_oe  = 4'hF;
        sio_out = ash[23:20];
        ph_d    = ~ph_q;
        if (ph_q) begin
          if (cnt_q == 4'd5) begin
            cnt_d   = 4'd0;
            state_d = wr_q ? DATA : DUMMY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DUMMY: begin
        sclk = ph_q;
        ce_n = ~ce_q;
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cnt_q == 4'(DUMMY_CYCLES - 1)) begin
            cnt_d   = 4'd0;
            state_d = DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        sclk = ph_q;
        ce_n = ~ce_q;
        ph_d = ~ph_q;
        if (wr_q) begin
          sio_oe  = 4'hF;
          sio_out = word_nib(wcur, cnt_q[1:0]);
          // Write word is consumed from the bus while its first nibble is on the pins.
          if (cnt_q == 4'd0 && !ph_q) begin
            wr_rdy = 1'b1;
            wsh_d  = wsrc;
          end
        end else if (ph_q) begin
          rsh_d = rword[11:0];
          if (cnt_q == 4'd3) begin
            rdata_d = {rword[7:0], rword[15:8]};
            rdy_d   = 1'b1;
          end
        end
        if (ph_q && cnt_q == (byte_q ? 4'd1 : 4'd3)) begin
          cnt_d   = 4'd0;
          words_d = words_q - 5'd1;
          if (words_q == 5'd1) state_d = END;
        end else if (ph_q) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      END: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          done    = 1'b1;
          ph_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= 4'd0;
      words_q <= 5'd0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      swap_q  <= 1'b0;
      ce_q    <= '0;
      rdata_q <= 16'h0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      swap_q  <= swap_d;
      ce_q    <= ce_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    op_q   <= op_d;
    wsh_q  <= wsh_d;
    rsh_q  <= rsh_d;
  end

endmodule

// File: tb/tb_lisa_qspi_engine.sv
// Directed bench for lisa_qspi_engine: per-cycle capture of pins and bus
// outputs after each request, checked against hand-computed cycle numbers.
module tb_lisa_qspi_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic [1:0] ce_n;
  logic [3:0] sio_out, sio_oe, sio_in;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  so_a  [0:200];
  logic [3:0]  oe_a  [0:200];
  logic [1:0]  ce_a  [0:200];
  logic        sc_a  [0:200];
  logic        rdy_a [0:200];
  logic        dn_a  [0:200];
  logic [15:0] rd_a  [0:200];
  logic [7:0]  rb0 [0:15];
  logic [7:0]  rb1 [0:15];
  logic [15:0] wq  [0:3];

  lisa_qspi_engine_if #(.CHIP_SELECTS(2)) bus ();

  lisa_qspi_engine #(.CHIP_SELECTS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sclk    (sclk),
    .ce_n    (ce_n),
    .sio_out (sio_out),
    .sio_oe  (sio_oe),
    .sio_in  (sio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request at the current point (#1 after an edge); returns in cycle 1.
  task automatic start_req(input logic [23:0] a, input logic [3:0] len, input logic [1:0] ws,
                           input logic [1:0] ce, input logic cust, input logic [7:0] cmd,
                           input bit hold_valid);
    bus.addr = a; bus.xfer_len = len; bus.wstrb = ws; bus.ce_ctrl = ce;
    bus.custom_spi_cmd = cust; bus.cmd_quad_write = cmd; bus.wdata = wq[0];
    bus.valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) bus.valid = 1'b0;
  endtask

  // Record cycles 1..n; feeds read nibbles from rb0/rb1 and next write words from wq.
  task automatic capture(input int n, input bit rd, input bit drop_on_rdy);
    int  widx;
    bit  adv;
    widx = 0;
    adv  = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (adv) begin
        widx++;
        if (widx < 4) bus.wdata = wq[widx];
        adv = 1'b0;
      end
      if (rd && c >= 29 && c < 29 + 8*16) begin
        int k, i;
        logic [7:0] b;
        k = (c - 29) / 8;
        i = ((c - 29) % 8) / 2;
        b = (i < 2) ? rb0[k] : rb1[k];
        sio_in = (i % 2 == 0) ? b[7:4] : b[3:0];
      end else begin
        sio_in = 4'h0;
      end
      #1;
      so_a[c] = sio_out; oe_a[c] = sio_oe; ce_a[c] = ce_n; sc_a[c] = sclk;
      rdy_a[c] = bus.ready; dn_a[c] = bus.xfer_done; rd_a[c] = bus.rdata;
      if (bus.ready && !rd) adv = 1'b1;
      if (bus.ready && drop_on_rdy) bus.valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic int cnt_rdy(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) if (rdy_a[c]) s++;
    return s;
  endfunction

  function automatic int cnt_dn(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) if (dn_a[c]) s++;
    return s;
  endfunction

  function automatic int first_dn(input int n);
    for (int c = 1; c <= n; c++) if (dn_a[c]) return c;
    return -1;
  endfunction

  // Nibbles sent in the first clk of each sclk period, starting at cycle c0.
  function automatic logic [31:0] pack(input int c0, input int nn);
    logic [31:0] v = 32'h0;
    for (int j = 0; j < nn; j++) v = {v[27:0], so_a[c0 + 2*j]};
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; sio_in = 4'h0;
    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0; bus.xfer_len = '0;
    bus.ce_ctrl = '0; bus.custom_spi_cmd = 1'b0; bus.cmd_quad_write = '0;
    for (int i = 0; i < 4; i++) wq[i] = 16'h0;
    for (int i = 0; i < 16; i++) begin rb0[i] = 8'h0; rb1[i] = 8'h0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", {30'h0, ce_n}, 32'h3);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_oe", {28'h0, sio_oe}, 32'h0);
    chk("rst_out", {28'h0, sio_out}, 32'h0);
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_done", {31'h0, bus.xfer_done}, 32'h0);
    chk("rst_rdata", {16'h0, bus.rdata}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-word read
    rb0[0] = 8'h34; rb1[0] = 8'h12;
    start_req(24'h000010, 4'd1, 2'b00, 2'b01, 1'b0, 8'h00, 1'b0);
    capture(45, 1'b1, 1'b0);
    chk("rd_ce_c1", {30'h0, ce_a[1]}, 32'h2);
    chk("rd_sclk_c1", {31'h0, sc_a[1]}, 32'h0);
    chk("rd_sclk_c2", {31'h0, sc_a[2]}, 32'h1);
    chk("rd_oe_c1", {28'h0, oe_a[1]}, 32'hF);
    chk("rd_cmdaddr", pack(1, 8), 32'hEB000010);
    chk("rd_oe_dummy", {28'h0, oe_a[17]}, 32'h0);
    chk("rd_ce_c36", {30'h0, ce_a[36]}, 32'h2);
    chk("rd_ce_c37", {30'h0, ce_a[37]}, 32'h3);
    chk("rd_rdy_c37", {31'h0, rdy_a[37]}, 32'h1);
    chk("rd_rdata", {16'h0, rd_a[37]}, 32'h1234);
    chk("rd_rdy_cnt", cnt_rdy(45), 32'd1);
    chk("rd_done_at", first_dn(45), 32'd38);
    chk("rd_done_cnt", cnt_dn(45), 32'd1);

    // Two-word write
    wq[0] = 16'hBEEF; wq[1] = 16'hCAFE;
    start_req(24'h000100, 4'd2, 2'b11, 2'b10, 1'b0, 8'h00, 1'b0);
    capture(40, 1'b0, 1'b0);
    chk("wr_cmdaddr", pack(1, 8), 32'h38000100);
    chk("wr_data", pack(17, 8), 32'hEFBEFECA);
    chk("wr_oe_data", {28'h0, oe_a[20]}, 32'hF);
    chk("wr_rdy_17", {31'h0, rdy_a[17]}, 32'h1);
    chk("wr_rdy_25", {31'h0, rdy_a[25]}, 32'h1);
    chk("wr_rdy_cnt", cnt_rdy(40), 32'd2);
    chk("wr_ce_c32", {30'h0, ce_a[32]}, 32'h1);
    chk("wr_ce_c33", {30'h0, ce_a[33]}, 32'h3);
    chk("wr_done_at", first_dn(40), 32'd34);
    chk("wr_done_cnt", cnt_dn(40), 32'd1);

    // Upper-byte write at top of address space, xfer_len ignored
    wq[0] = 16'hA500;
    start_req(24'hFFFFFF, 4'd5, 2'b10, 2'b01, 1'b0, 8'h00, 1'b0);
    capture(30, 1'b0, 1'b0);
    chk("bw_cmdaddr", pack(1, 8), 32'h38000000);
    chk("bw_data", pack(17, 2), 32'h000000A5);
    chk("bw_rdy_cnt", cnt_rdy(30), 32'd1);
    chk("bw_rdy_17", {31'h0, rdy_a[17]}, 32'h1);
    chk("bw_ce_c21", {30'h0, ce_a[21]}, 32'h3);
    chk("bw_done_at", first_dn(30), 32'd22);

    // Custom write opcode, then read with the same flag
    wq[0] = 16'h1357;
    start_req(24'h000200, 4'd1, 2'b11, 2'b01, 1'b1, 8'h02, 1'b0);
    capture(30, 1'b0, 1'b0);
    chk("cw_op", pack(1, 2), 32'h02);
    chk("cw_data", pack(17, 4), 32'h00005713);
    chk("cw_done_at", first_dn(30), 32'd26);
    rb0[0] = 8'h78; rb1[0] = 8'h56;
    start_req(24'h000200, 4'd1, 2'b00, 2'b01, 1'b1, 8'h02, 1'b0);
    capture(40, 1'b1, 1'b0);
    chk("cr_op", pack(1, 2), 32'hEB);
    chk("cr_rdata", {16'h0, rd_a[37]}, 32'h5678);

    // Sixteen-word read (xfer_len=0), valid held until the first ready
    for (int i = 0; i < 16; i++) begin rb0[i] = 8'(i); rb1[i] = 8'hA0 + 8'(i); end
    start_req(24'h001000, 4'd0, 2'b00, 2'b01, 1'b0, 8'h00, 1'b1);
    capture(170, 1'b1, 1'b1);
    chk("l16_rdy_cnt", cnt_rdy(170), 32'd16);
    chk("l16_rdy_45", {31'h0, rdy_a[45]}, 32'h1);
    chk("l16_rd_45", {16'h0, rd_a[45]}, 32'hA101);
    chk("l16_rdy_157", {31'h0, rdy_a[157]}, 32'h1);
    chk("l16_rd_157", {16'h0, rd_a[157]}, 32'hAF0F);
    chk("l16_done_at", first_dn(170), 32'd158);
    chk("l16_done_cnt", cnt_dn(170), 32'd1);
    chk("l16_ce_idle", {30'h0, ce_a[165]}, 32'h3);

    // Reset asserted during ADDR, then a clean read
    start_req(24'h123456, 4'd1, 2'b00, 2'b10, 1'b0, 8'h00, 1'b0);
    capture(8, 1'b1, 1'b0);
    chk("ra_ce_before", {30'h0, ce_n}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ra_ce_n", {30'h0, ce_n}, 32'h3);
    chk("ra_oe", {28'h0, sio_oe}, 32'h0);
    chk("ra_sclk", {31'h0, sclk}, 32'h0);
    chk("ra_done", {31'h0, bus.xfer_done}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rb0[0] = 8'hCD; rb1[0] = 8'hEF;
    start_req(24'h0000AB, 4'd1, 2'b00, 2'b01, 1'b0, 8'h00, 1'b0);
    capture(45, 1'b1, 1'b0);
    chk("ra2_cmdaddr", pack(1, 8), 32'hEB0000AB);
    chk("ra2_rdy_37", {31'h0, rdy_a[37]}, 32'h1);
    chk("ra2_rdata", {16'h0, rd_a[37]}, 32'hEFCD);
    chk("ra2_done_at", first_dn(45), 32'd38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lisa_qspi_engine.md
# lisa_qspi_engine

Terminal QSPI PSRAM engine sitting behind the LISA QSPI arbiter: it accepts one arbitrated request (address, length, chip-select, read/write) and executes it as a quad-mode command/address/dummy/data sequence on the external QSPI pins. It returns per-word `ready` strobes with read data or write-data consumption, then a single `xfer_done` pulse. It is the responder side of the arbiter's downstream request bus.

## Interface

- CHIP_SELECTS, 2, number of external CE lines
- DUMMY_CYCLES, 6, sclk cycles of dummy between address and read data
- CMD_READ, 8'hEB, quad read opcode
- CMD_WRITE, 8'h38, default quad write opcode

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  24  byte address of first word
- rdata  out  16  read word, valid while `ready`=1, held until next read word
- wdata  in  16  write word
- wstrb  in  2  0 = read; 2'b11 = word write; 2'b01/2'b10 = single-byte write
- ready  out  1  one-clk pulse per word (read data valid / write word consumed)
- xfer_done  out  1  one-clk pulse at end of transaction
- valid  in  1  request; sampled only in IDLE, need not be held afterwards
- xfer_len  in  4  16-bit words to transfer; 0 means 16
- ce_ctrl  in  CHIP_SELECTS  one-hot CE selection
- custom_spi_cmd  in  1  write uses `cmd_quad_write` instead of CMD_WRITE
- cmd_quad_write  in  8  custom write opcode
- sclk  out  1  QSPI clock, idle low
- ce_n  out  CHIP_SELECTS  active-low chip enables
- sio_out  out  4  quad data out
- sio_oe  out  4  output enables (all-or-none)
- sio_in  in  4  quad data in

## Operation

- States: IDLE, CMD, ADDR, DUMMY, DATA, END.
- IDLE: on clk edge with `valid`=1 latch addr, wstrb, xfer_len, ce_ctrl, custom_spi_cmd, cmd_quad_write; go to CMD. Inputs ignored outside IDLE.
- Each nibble = one sclk period = 2 clk: first clk sclk=0 with sio_out driven; second clk sclk=1. Input nibble sampled at the edge ending the sclk=1 clk.
- CMD: 2 nibbles, opcode MSB-nibble first. Opcode = CMD_READ if wstrb=0; else cmd_quad_write if custom_spi_cmd, else CMD_WRITE.
- ADDR: 6 nibbles, MSB first. If wstrb=2'b10, address sent is addr+1 (24-bit wrap).
- DUMMY: reads only, DUMMY_CYCLES sclk periods, sio_oe=0.
- DATA read: per word 4 nibbles; low byte (high nibble first) then high byte; rdata = {byte1, byte0}; `ready` pulses in clk after 4th sample.
- DATA write word: wdata captured into shift register on the clk the word's first nibble is driven; `ready` pulses that same clk; initiator must present next word within 7 clk. Byte order as for read.
- Single-byte write (wstrb 01/10): exactly 2 nibbles of wdata[7:0] or wdata[15:8]; length forced to 1 regardless of xfer_len; one `ready`.
- Word counter decrements per word; on last word go to END.
- END: 2 clk with all ce_n high, sclk=0, sio_oe=0; `xfer_done` pulses on second; then IDLE. New request accepted earliest the clk after xfer_done.
- ce_n = ~latched ce_ctrl from CMD through DATA; all 1 otherwise. ce_ctrl=0: sequence runs normally, no CE asserted.
- sio_oe=4'hF in CMD, ADDR, write DATA; 0 else. sio_out=0 when not driving.

## Timing

- Reset (async, any state, including mid-transaction): IDLE, ce_n all 1, sclk 0, sio_oe 0, sio_out 0, ready 0, xfer_done 0, rdata 16'h0, counters 0.
- Cycle 1 = first clk after accepting edge (ce_n low). CMD 1-4, ADDR 5-16.
- Read, default DUMMY_CYCLES: dummy 17-28, word k (k=0..) data 29+8k..36+8k, ready in 37+8k. Last word N-1: ready coincides with first END clk; xfer_done at 38+8(N-1).
- Write word: word k data 17+8k..24+8k, ready in 17+8k; END 25+8(N-1), 26+8(N-1); xfer_done at 26+8(N-1).
- Byte write: data 17-20, ready in 17, xfer_done in 22.
- `ready` and `xfer_done` never high in same clk for writes; at most one pulse per clk.

## Test plan

- Read addr=24'h000010, xfer_len=1, ce_ctrl=01, model returns bytes 34,12 -> ce_n[0] low cycles 1-36, sio_out EB then 000010, ready at 37 with rdata=16'h1234, xfer_done at 38.
- Write addr=24'h000100, wstrb=11, xfer_len=2, wdata 16'hBEEF then 16'hCAFE -> opcode 38, nibbles E,F,B,E,F,E,A,C; ready at 17 and 25; xfer_done at 34.
- Byte write wstrb=10, addr=24'hFFFFFF, wdata=16'hA500, xfer_len=5 -> address 000000, nibbles A,5 only, one ready, xfer_done at 22.
- custom_spi_cmd=1, cmd_quad_write=8'h02 write -> opcode nibbles 0,2; read with same flag -> still EB.
- xfer_len=0 read -> 16 ready pulses spaced 8 clk, one xfer_done; valid dropped after first ready has no effect.
- rst_n low during ADDR -> immediately ce_n=all 1, sio_oe=0, no xfer_done; next valid after release starts a clean transaction with standard timing.
